// File: rtl/riio_por_reset_seq.sv
// Power-on-reset sequencer: synchronises and glitch-filters POR_N_I, then releases NUM_CH
// reset domains in order. Software re-sequencing is built only with RIIO_POR_SEQ_SW_RST_EN.
module riio_por_reset_seq #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned STAGE_CYCLES  = 8
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic              POR_N_I,
  input  logic              SW_RST_REQ_I,
  output logic              SW_RST_ACK_O,
  output logic [NUM_CH-1:0] RST_N_O,
  output logic              READY_O,
  output logic [1:0]        STATE_O
);

  localparam int unsigned CNT_MAX = (FILTER_CYCLES > STAGE_CYCLES) ? FILTER_CYCLES : STAGE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned CH_W    = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0]  FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH_ONE      = NUM_CH'(1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_FILTER  = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_por_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CH_W-1:0]        r_ch;
  logic [NUM_CH-1:0]      r_rst_n;
  logic [NUM_CH-1:0]      w_rel_mask;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], POR_N_I};
    end
  end

  assign w_por_s    = r_sync[SYNC_STAGES-1];
  assign w_rel_mask = CH_ONE << r_ch;

`ifdef RIIO_POR_SEQ_SW_RST_EN
  logic r_ack;
`endif

  // A low synchronised POR overrides every state; HOLD itself only leaves on a high POR.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_rst_n <= '0;
`ifdef RIIO_POR_SEQ_SW_RST_EN
      r_ack   <= 1'b0;
`endif
    end else begin
`ifdef RIIO_POR_SEQ_SW_RST_EN
      r_ack <= 1'b0;
`endif
      if (!w_por_s) begin
        r_state <= S_HOLD;
        r_cnt   <= '0;
        r_ch    <= '0;
        r_rst_n <= '0;
      end else begin
        case (r_state)
          S_HOLD: begin
            r_state <= S_FILTER;
            r_cnt   <= '0;
          end
          S_FILTER: begin
            if (r_cnt == FILTER_LAST) begin
              r_state <= S_RELEASE;
              r_cnt   <= '0;
              r_ch    <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (r_cnt == STAGE_LAST) begin
              r_rst_n <= r_rst_n | w_rel_mask;
              r_cnt   <= '0;
              r_ch    <= r_ch + 1'b1;
              if (r_ch == CH_LAST) begin
                r_state <= S_DONE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
`ifdef RIIO_POR_SEQ_SW_RST_EN
            if (SW_RST_REQ_I) begin
              r_state <= S_FILTER;
              r_cnt   <= '0;
              r_ch    <= '0;
              r_rst_n <= '0;
              r_ack   <= 1'b1;
            end
`endif
          end
          default: begin
            r_state <= S_HOLD;
          end
        endcase
      end
    end
  end

`ifdef RIIO_POR_SEQ_SW_RST_EN
  assign SW_RST_ACK_O = r_ack;
`else
  logic w_unused_sw_req;
  assign w_unused_sw_req = SW_RST_REQ_I;
  assign SW_RST_ACK_O    = 1'b0;
`endif

  assign RST_N_O = r_rst_n;
  assign READY_O = (r_state == S_DONE);
  assign STATE_O = r_state;

endmodule

// File: tb/tb_riio_por_reset_seq.sv
// Self-checking bench for riio_por_reset_seq: directed release/drop/reset scenarios plus
// randomized POR, software-request and reset activity against an edge-timing reference model.
module tb_riio_por_reset_seq;

  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned FILTER_CYCLES = 16;
  localparam int unsigned STAGE_CYCLES  = 8;

  logic              CLK_I = 1'b0;
  logic              RST_N_I;
  logic              POR_N_I;
  logic              SW_RST_REQ_I;
  logic              SW_RST_ACK_O;
  logic [NUM_CH-1:0] RST_N_O;
  logic              READY_O;
  logic [1:0]        STATE_O;

  riio_por_reset_seq #(
    .NUM_CH       (NUM_CH),
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .STAGE_CYCLES (STAGE_CYCLES)
  ) dut (
    .CLK_I       (CLK_I),
    .RST_N_I     (RST_N_I),
    .POR_N_I     (POR_N_I),
    .SW_RST_REQ_I(SW_RST_REQ_I),
    .SW_RST_ACK_O(SW_RST_ACK_O),
    .RST_N_O     (RST_N_O),
    .READY_O     (READY_O),
    .STATE_O     (STATE_O)
  );

  always #5 CLK_I = ~CLK_I;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: while active, outputs follow from the edge at which FILTER was entered.
  bit          m_por_q[$];
  bit          m_active;
  bit          m_ack;
  int unsigned m_edge;
  int unsigned m_start;

  task automatic m_reset();
    m_por_q = {};
    for (int unsigned i = 0; i < SYNC_STAGES; i++) m_por_q.push_back(1'b0);
    m_active = 1'b0;
    m_ack    = 1'b0;
    m_edge   = 0;
    m_start  = 0;
  endtask

  task automatic m_expect(output logic [NUM_CH-1:0] rst, output logic [1:0] st);
    int unsigned e;
    int unsigned n;
    rst = '0;
    st  = 2'd0;
    n   = 0;
    if (m_active) begin
      e = m_edge - m_start;
      if (e < FILTER_CYCLES) begin
        st = 2'd1;
      end else begin
        n = (e - FILTER_CYCLES) / STAGE_CYCLES;
        if (n >= NUM_CH) begin
          n  = NUM_CH;
          st = 2'd3;
        end else begin
          st = 2'd2;
        end
      end
      for (int unsigned k = 0; k < NUM_CH; k++) if (k < n) rst[k] = 1'b1;
    end
  endtask

  task automatic m_step();
    bit                pors_prev;
    logic [NUM_CH-1:0] r_prev;
    logic [1:0]        st_prev;
    pors_prev = m_por_q[0];
    m_expect(r_prev, st_prev);
    m_edge++;
    m_ack = 1'b0;
    m_por_q.push_back(POR_N_I);
    void'(m_por_q.pop_front());
    if (!m_active) begin
      if (pors_prev) begin
        m_active = 1'b1;
        m_start  = m_edge;
      end
    end else if (!pors_prev) begin
      m_active = 1'b0;
    end
`ifdef RIIO_POR_SEQ_SW_RST_EN
    else if (st_prev == 2'd3 && SW_RST_REQ_I) begin
      m_start = m_edge;
      m_ack   = 1'b1;
    end
`endif
  endtask

  task automatic check_all();
    logic [NUM_CH-1:0] er;
    logic [1:0]        es;
    m_expect(er, es);
    check("rst_n", 32'(RST_N_O), 32'(er));
    check("state", 32'(STATE_O), 32'(es));
    check("ready", 32'(READY_O), 32'(es == 2'd3));
    check("ack", 32'(SW_RST_ACK_O), 32'(m_ack));
  endtask

  // mode 1: edges counted from the first edge sampling POR high; mode 2: from the SW request.
  int unsigned mode     = 0;
  int unsigned rel_edge = 0;

  task automatic edge_checks();
    if (mode == 1) begin
      case (rel_edge)
        2:  check("e2_state", 32'(STATE_O), 32'd0);
        3:  check("e3_state", 32'(STATE_O), 32'd1);
        18: check("e18_state", 32'(STATE_O), 32'd1);
        19: check("e19_state", 32'(STATE_O), 32'd2);
        26: check("e26_rst", 32'(RST_N_O), 32'h0);
        27: check("e27_rst", 32'(RST_N_O), 32'h1);
        34: check("e34_rst", 32'(RST_N_O), 32'h1);
        35: check("e35_rst", 32'(RST_N_O), 32'h3);
        43: check("e43_rst", 32'(RST_N_O), 32'h7);
        50: check("e50_ready", 32'(READY_O), 32'd0);
        51: begin
          check("e51_rst", 32'(RST_N_O), 32'hF);
          check("e51_ready", 32'(READY_O), 32'd1);
          check("e51_state", 32'(STATE_O), 32'd3);
        end
        default: ;
      endcase
    end else if (mode == 2) begin
`ifdef RIIO_POR_SEQ_SW_RST_EN
      case (rel_edge)
        1: begin
          check("sw_ack_pulse", 32'(SW_RST_ACK_O), 32'd1);
          check("sw_rst_clear", 32'(RST_N_O), 32'h0);
          check("sw_state", 32'(STATE_O), 32'd1);
        end
        2:  check("sw_ack_end", 32'(SW_RST_ACK_O), 32'd0);
        24: check("sw_bit0_early", 32'(RST_N_O), 32'h0);
        25: check("sw_bit0_rise", 32'(RST_N_O), 32'h1);
        49: check("sw_done", 32'(RST_N_O), 32'hF);
        default: ;
      endcase
`else
      case (rel_edge)
        1:  begin
          check("nosw_ack", 32'(SW_RST_ACK_O), 32'd0);
          check("nosw_rst", 32'(RST_N_O), 32'hF);
        end
        25: check("nosw_rst_hold", 32'(RST_N_O), 32'hF);
        default: ;
      endcase
`endif
    end
  endtask

  task automatic cycle();
    @(posedge CLK_I);
    if (!RST_N_I) m_reset();
    else m_step();
    rel_edge++;
    @(negedge CLK_I);
    check_all();
    edge_checks();
    if (m_ack) SW_RST_REQ_I = 1'b0;
  endtask

  task automatic async_reset_pulse();
    RST_N_I = 1'b0;
    #1;
    m_reset();
    check("async_rst_n", 32'(RST_N_O), 32'h0);
    check("async_ready", 32'(READY_O), 32'd0);
    check("async_state", 32'(STATE_O), 32'd0);
    check("async_ack", 32'(SW_RST_ACK_O), 32'd0);
  endtask

  int unsigned hold;
  bit          seen_filter;

  initial begin
    RST_N_I      = 1'b0;
    POR_N_I      = 1'b0;
    SW_RST_REQ_I = 1'b0;
    m_reset();
    repeat (3) cycle();

    // Clean power-up with the default edge timing.
    RST_N_I = 1'b1; POR_N_I = 1'b1; mode = 1; rel_edge = 0;
    repeat (56) cycle();

    // Software request in DONE, dropped once acknowledged.
    SW_RST_REQ_I = 1'b1; mode = 2; rel_edge = 0;
    repeat (60) cycle();
    SW_RST_REQ_I = 1'b0; mode = 0;

    // POR drop while DONE, then a full repeat of the release.
    POR_N_I = 1'b0;
    repeat (3) cycle();
    check("por_drop_rst", 32'(RST_N_O), 32'h0);
    check("por_drop_ready", 32'(READY_O), 32'd0);
    repeat (2) cycle();
    POR_N_I = 1'b1; mode = 1; rel_edge = 0;
    repeat (56) cycle();

    // Block reset pulsed mid-RELEASE with two domains out.
    POR_N_I = 1'b0; mode = 0;
    repeat (4) cycle();
    POR_N_I = 1'b1; mode = 1; rel_edge = 0;
    repeat (36) cycle();
    check("pre_async_rst", 32'(RST_N_O), 32'h3);
    async_reset_pulse();
    mode = 0;
    cycle();
    RST_N_I = 1'b1; mode = 1; rel_edge = 0;
    repeat (56) cycle();

    // Short POR high: FILTER entered and abandoned, no release.
    POR_N_I = 1'b0; mode = 0;
    repeat (4) cycle();
    POR_N_I = 1'b1;
    seen_filter = 1'b0;
    repeat (10) begin
      cycle();
      if (STATE_O == 2'd1) seen_filter = 1'b1;
    end
    POR_N_I = 1'b0;
    repeat (6) cycle();
    check("glitch_filter_seen", 32'(seen_filter), 32'd1);
    check("glitch_back_hold", 32'(STATE_O), 32'd0);

    // Randomized POR, software-request and block-reset activity.
    hold = 0;
    repeat (4000) begin
      if (hold == 0) begin
        POR_N_I = ~POR_N_I;
        hold = POR_N_I ? $urandom_range(1, 120) : $urandom_range(1, 6);
      end else begin
        hold--;
      end
      if (!SW_RST_REQ_I && $urandom_range(0, 29) == 0) SW_RST_REQ_I = 1'b1;
      else if (SW_RST_REQ_I && $urandom_range(0, 9) == 0) SW_RST_REQ_I = 1'b0;
      if (!RST_N_I) RST_N_I = 1'b1;
      else if ($urandom_range(0, 299) == 0) async_reset_pulse();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
